cache_axi_bridge: RTL and testbench

- Sits directly downstream of the L1 cache miss/uncache port; converts its rd_req/ret and wr_req handshakes into AXI4 master transactions (32-bit data).
- One read and one write FSM; at most one read and one write in flight; 16-byte line bursts (4 beats) or single transfers for uncached accesses.
- Read-after-write ordering is guaranteed by blocking reads while a write is in progress.

---
 rtl/cache_axi_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns the L1 cache rd/wr handshakes into AXI4 master transactions.
// One read and one write in flight; line accesses become 4-beat INCR bursts.
module cache_axi_bridge #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_BEATS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  localparam logic [7:0] LINE_LEN  = 8'(LINE_BEATS - 1);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} wr_state_e;

  rd_state_e      rd_state_r;
  logic [2:0]     rd_type_r;
  logic [31:0]    rd_addr_r;
  logic           arvalid_r;
  logic           rready_r;

  wr_state_e      wr_state_r;
  logic [2:0]     wr_type_r;
  logic [31:0]    wr_addr_r;
  logic [3:0]     wr_strb_r;
  logic [127:0]   wr_data_r;
  logic           awvalid_r;
  logic           wvalid_r;
  logic           bready_r;
  logic           aw_done_r;
  logic           w_done_r;
  logic [1:0]     beat_r;

  logic           rd_line_s;
  logic           wr_line_s;
  logic [1:0]     word_sel_s;
  logic           wlast_s;
  logic           aw_ok_s;
  logic           w_ok_s;
  logic           unused_ok;

  // Reads wait for the write side to be fully idle, including a write requested this cycle.
  assign rd_rdy = resetn && (rd_state_r == R_IDLE) && (wr_state_r == W_IDLE) && !wr_req;
  assign wr_rdy = resetn && (wr_state_r == W_IDLE);

  assign rd_line_s = (rd_type_r == TYPE_LINE);
  assign arid      = AXI_ID;
  assign araddr    = rd_addr_r;
  assign arlen     = rd_line_s ? LINE_LEN : 8'd0;
  assign arsize    = rd_line_s ? 3'b010 : {1'b0, rd_type_r[1:0]};
  assign arburst   = 2'b01;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;

  assign ret_valid = rvalid && rready_r;
  assign ret_last  = rvalid && rlast && rready_r;
  assign ret_data  = rdata;

  // Uncached writes take the word sitting at the address's offset within the line.
  assign wr_line_s  = (wr_type_r == TYPE_LINE);
  assign word_sel_s = wr_line_s ? beat_r : wr_addr_r[3:2];
  assign wlast_s    = wr_line_s ? (beat_r == LINE_LEN[1:0]) : 1'b1;
  assign awid       = AXI_ID;
  assign awaddr     = wr_addr_r;
  assign awlen      = wr_line_s ? LINE_LEN : 8'd0;
  assign awsize     = wr_line_s ? 3'b010 : {1'b0, wr_type_r[1:0]};
  assign awburst    = 2'b01;
  assign awvalid    = awvalid_r;
  assign wdata      = wr_data_r[{word_sel_s, 5'd0} +: 32];
  assign wstrb      = wr_line_s ? 4'hf : wr_strb_r;
  assign wlast      = wlast_s;
  assign wvalid     = wvalid_r;
  assign bready     = bready_r;

  assign aw_ok_s   = aw_done_r || (awvalid_r && awready);
  assign w_ok_s    = w_done_r || (wvalid_r && wready && wlast_s);
  assign unused_ok = ^{rid, rresp, bid, bresp};

  // Read FSM: request latch, AR handshake, then stream R beats back to the cache.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_r <= R_IDLE;
      rd_type_r  <= 3'd0;
      rd_addr_r  <= 32'd0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
    end else begin
      case (rd_state_r)
        R_IDLE: if (rd_req && rd_rdy) begin
          rd_type_r  <= rd_type;
          rd_addr_r  <= rd_addr;
          arvalid_r  <= 1'b1;
          rd_state_r <= R_AR;
        end
        R_AR: if (arready) begin
          arvalid_r  <= 1'b0;
          rready_r   <= 1'b1;
          rd_state_r <= R_DATA;
        end
        R_DATA: if (rvalid && rlast) begin
          rready_r   <= 1'b0;
          rd_state_r <= R_IDLE;
        end
        default: begin
          arvalid_r  <= 1'b0;
          rready_r   <= 1'b0;
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: AW and W run independently; the response phase starts once both are done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_r <= W_IDLE;
      wr_type_r  <= 3'd0;
      wr_addr_r  <= 32'd0;
      wr_strb_r  <= 4'd0;
      wr_data_r  <= 128'd0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      beat_r     <= 2'd0;
    end else begin
      case (wr_state_r)
        W_IDLE: if (wr_req) begin
          wr_type_r  <= wr_type;
          wr_addr_r  <= wr_addr;
          wr_strb_r  <= wr_wstrb;
          wr_data_r  <= wr_data;
          awvalid_r  <= 1'b1;
          wvalid_r   <= 1'b1;
          aw_done_r  <= 1'b0;
          w_done_r   <= 1'b0;
          beat_r     <= 2'd0;
          wr_state_r <= W_SEND;
        end
        W_SEND: begin
          if (awvalid_r && awready) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (wvalid_r && wready) begin
            beat_r <= beat_r + 2'd1;
            if (wlast_s) begin
              wvalid_r <= 1'b0;
              w_done_r <= 1'b1;
            end
          end
          if (aw_ok_s && w_ok_s) begin
            bready_r   <= 1'b1;
            wr_state_r <= W_RESP;
          end
        end
        W_RESP: if (bvalid) begin
          bready_r   <= 1'b0;
          wr_state_r <= W_IDLE;
        end
        default: begin
          awvalid_r  <= 1'b0;
          wvalid_r   <= 1'b0;
          bready_r   <= 1'b0;
          wr_state_r <= W_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: AXI slave responders with random delays,
// directed scenarios followed by randomized traffic checked against expected transactions.
module tb_cache_axi_bridge;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_rdy;
  logic [3:0]   arid, awid;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]   wstrb;
  logic         arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [3:0]   rid = 4'd0, bid = 4'd0;
  logic [31:0]  rdata = 32'd0;
  logic [1:0]   rresp = 2'd0, bresp = 2'd0;
  logic         rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

  always #5 clk = ~clk;

  cache_axi_bridge #(.AXI_ID(4'd0), .LINE_BEATS(4)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [3:0] id; } ax_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } beat_t;

  ax_t   ar_q[$], aw_q[$], rs_q[$];
  beat_t w_q[$], ret_q[$];
  logic [31:0] mem [logic [31:0]];

  int compared = 0, mismatched = 0;
  int cyc = 0, ret_done = 0, b_cnt = 0, aw_cnt = 0, wl_cnt = 0, b_given = 0;
  int b_cyc = 0, ar_rise_cyc = 0, ar_wait = 0, aw_wait = 0;
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, w_rand = 1'b0, arvalid_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'ha5c3_0f1e;
  endfunction

  // Handshake monitor: everything is sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      {ar_hs, r_hs, aw_hs, w_hs, b_hs} = 5'd0;
      rs_q.delete();
      aw_cnt = 0;
      wl_cnt = 0;
    end else begin
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (arvalid && !arvalid_prev) ar_rise_cyc = cyc;
      if (ar_hs) begin
        ar_q.push_back('{addr:araddr, len:arlen, size:arsize, burst:arburst, id:arid});
        rs_q.push_back('{addr:araddr, len:arlen, size:arsize, burst:arburst, id:arid});
      end
      if (aw_hs) begin
        aw_q.push_back('{addr:awaddr, len:awlen, size:awsize, burst:awburst, id:awid});
        aw_cnt++;
      end
      if (w_hs) begin
        w_q.push_back('{data:wdata, strb:wstrb, last:wlast});
        if (wlast) wl_cnt++;
      end
      if (ret_valid) ret_q.push_back('{data:ret_data, strb:4'h0, last:ret_last});
      if (ret_valid && ret_last) ret_done++;
      if (b_hs) begin b_cnt++; b_cyc = cyc; end
    end
    arvalid_prev = arvalid;
  end

  initial begin : ar_slave
    forever begin
      @(posedge clk); #1;
      if (!resetn || !arvalid) arready = 1'b0;
      else if (!arready) begin
        if (ar_wait > 0) ar_wait--; else arready = 1'b1;
      end
    end
  end

  initial begin : r_slave
    ax_t t;
    logic [31:0] r_base;
    logic [7:0] r_len;
    int r_beat;
    bit r_act;
    r_act = 1'b0; r_beat = 0; r_len = 8'd0; r_base = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        rvalid = 1'b0; rlast = 1'b0; r_act = 1'b0;
      end else begin
        if (r_hs) begin
          rvalid = 1'b0; rlast = 1'b0;
          if (r_beat == int'(r_len)) r_act = 1'b0; else r_beat++;
        end
        if (!r_act && rs_q.size() > 0) begin
          t = rs_q.pop_front();
          r_base = {t.addr[31:2], 2'b00}; r_len = t.len; r_beat = 0; r_act = 1'b1;
        end
        if (r_act && !rvalid && $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rdata  = mem_word(r_base + 32'(4 * r_beat));
          rlast  = (r_beat == int'(r_len));
          rresp  = 2'($urandom);
        end
      end
    end
  end

  initial begin : aw_w_b_slave
    forever begin
      @(posedge clk); #1;
      if (!resetn || !awvalid) awready = 1'b0;
      else if (!awready) begin
        if (aw_wait > 0) aw_wait--; else awready = 1'b1;
      end
      wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!resetn) begin
        bvalid = 1'b0; b_given = 0;
      end else begin
        if (b_hs) begin bvalid = 1'b0; b_given++; end
        if (!bvalid && aw_cnt > b_given && wl_cnt > b_given && $urandom_range(0, 2) != 0) begin
          bvalid = 1'b1; bresp = 2'($urandom);
        end
      end
    end
  end

  task automatic wait_rd_accept();
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (!rd_rdy && n < 400);
    if (n >= 400) check("rd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic issue_read(input logic [2:0] t, input logic [31:0] a);
    @(posedge clk); #1;
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    wait_rd_accept();
  endtask

  task automatic issue_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
    int n = 0;
    @(posedge clk); #1;
    while (!wr_rdy && n < 400) begin @(negedge clk); #1; n++; end
    if (n >= 400) check("wr_accept_timeout", 32'd0, 32'd1);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic wait_read_done(input int target);
    int n = 0;
    while (ret_done < target && n < 400) begin @(negedge clk); #1; n++; end
    if (n >= 400) check("read_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_write_done(input int target);
    int n = 0;
    while (b_cnt < target && n < 400) begin @(negedge clk); #1; n++; end
    if (n >= 400) check("write_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify_read(input logic [2:0] t, input logic [31:0] a);
    ax_t r;
    bit line;
    int nb;
    logic [31:0] exp_d;
    line = (t == 3'b100);
    nb = line ? 4 : 1;
    check("ar_count", ar_q.size(), 32'd1);
    if (ar_q.size() > 0) begin
      r = ar_q.pop_front();
      check("araddr", r.addr, a);
      check("arlen", r.len, line ? 32'd3 : 32'd0);
      check("arsize", r.size, line ? 32'd2 : {30'd0, t[1:0]});
      check("arburst", r.burst, 32'd1);
      check("arid", r.id, 32'd0);
    end
    check("ret_count", ret_q.size(), nb);
    for (int k = 0; k < nb && ret_q.size() > 0; k++) begin
      beat_t b = ret_q.pop_front();
      exp_d = line ? mem_word(a + 32'(4 * k)) : mem_word({a[31:2], 2'b00});
      check("ret_data", b.data, exp_d);
      check("ret_last", b.last, (k == nb - 1) ? 32'd1 : 32'd0);
    end
    ar_q.delete(); ret_q.delete();
  endtask

  task automatic verify_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
    ax_t r;
    bit line;
    int nb, widx;
    line = (t == 3'b100);
    nb = line ? 4 : 1;
    check("aw_count", aw_q.size(), 32'd1);
    if (aw_q.size() > 0) begin
      r = aw_q.pop_front();
      check("awaddr", r.addr, a);
      check("awlen", r.len, line ? 32'd3 : 32'd0);
      check("awsize", r.size, line ? 32'd2 : {30'd0, t[1:0]});
      check("awburst", r.burst, 32'd1);
      check("awid", r.id, 32'd0);
    end
    check("w_count", w_q.size(), nb);
    for (int k = 0; k < nb && w_q.size() > 0; k++) begin
      beat_t b = w_q.pop_front();
      widx = line ? k : int'(a[3:2]);
      check("wdata", b.data, d[32 * widx +: 32]);
      check("wstrb", b.strb, line ? 32'hf : {28'd0, s});
      check("wlast", b.last, (k == nb - 1) ? 32'd1 : 32'd0);
    end
    aw_q.delete(); w_q.delete();
  endtask

  function automatic logic [31:0] rand_addr(input logic [2:0] t);
    logic [31:0] a;
    a = $urandom;
    if (t == 3'b100) a[3:0] = 4'd0;
    else if (t == 3'b010) a[1:0] = 2'd0;
    else if (t == 3'b001) a[0] = 1'b0;
    else a = a;
    return a;
  endfunction

  initial begin : stim
    int rt_tgt, wb_tgt, mode, tsel;
    logic [2:0] rt, wt;
    logic [31:0] ra, wa;
    logic [3:0] ws;
    logic [127:0] wd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    check("rst_rd_rdy", rd_rdy, 32'd0);
    check("rst_wr_rdy", wr_rdy, 32'd0);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, ret_valid}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk); #1;
    check("post_rst_rd_rdy", rd_rdy, 32'd1);
    check("post_rst_wr_rdy", wr_rdy, 32'd1);

    // Line read with known data and arready after 2 cycles
    mem[32'h1c000040] = 32'h11; mem[32'h1c000044] = 32'h22;
    mem[32'h1c000048] = 32'h33; mem[32'h1c00004c] = 32'h44;
    ar_wait = 2;
    rt_tgt = ret_done + 1;
    issue_read(3'b100, 32'h1c000040);
    wait_read_done(rt_tgt);
    @(negedge clk); #1;
    check("rd_rdy_after_last", rd_rdy, 32'd1);
    verify_read(3'b100, 32'h1c000040);

    // Uncached word read: arvalid must hold until arready
    ar_wait = 5;
    rt_tgt = ret_done + 1;
    issue_read(3'b010, 32'hbfaf8004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("arvalid_hold", arvalid, 32'd1);
    end
    wait_read_done(rt_tgt);
    verify_read(3'b010, 32'hbfaf8004);

    // Line write with awready arriving well after the W beats
    aw_wait = 7; w_rand = 1'b0;
    wd = 128'h00000044_00000033_00000022_00000011;
    wb_tgt = b_cnt + 1;
    issue_write(3'b100, 32'h1c000080, 4'h0, wd);
    wait_write_done(wb_tgt);
    check("wr_rdy_before_b", wr_rdy, 32'd0);
    @(negedge clk); #1;
    check("wr_rdy_after_b", wr_rdy, 32'd1);
    verify_write(3'b100, 32'h1c000080, 4'h0, wd);

    // Uncached byte write
    aw_wait = 1;
    wd = {32'h01234567, 32'haabbccdd, 32'h89abcdef, 32'h55aa55aa};
    wb_tgt = b_cnt + 1;
    issue_write(3'b000, 32'hbfaf8008, 4'b0100, wd);
    wait_write_done(wb_tgt);
    verify_write(3'b000, 32'hbfaf8008, 4'b0100, wd);

    // Simultaneous read and write: write wins, read waits for B
    w_rand = 1'b1; aw_wait = 2; ar_wait = 1;
    wd = {$urandom, $urandom, $urandom, $urandom};
    rt_tgt = ret_done + 1; wb_tgt = b_cnt + 1;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h1c0000c0; wr_wstrb = 4'h0; wr_data = wd;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1c000100;
    @(negedge clk); #1;
    check("simul_rd_rdy", rd_rdy, 32'd0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    wait_rd_accept();
    wait_write_done(wb_tgt);
    wait_read_done(rt_tgt);
    check("raw_order", (ar_rise_cyc > b_cyc) ? 32'd1 : 32'd0, 32'd1);
    verify_write(3'b100, 32'h1c0000c0, 4'h0, wd);
    verify_read(3'b100, 32'h1c000100);

    // Reset in the middle of a line read
    ar_wait = 0;
    issue_read(3'b100, 32'h1c000140);
    for (int n = 0; n < 400 && ret_q.size() < 1; n++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk); #1;
    check("midrst_rd_rdy", rd_rdy, 32'd0);
    check("midrst_wr_rdy", wr_rdy, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("midrst_valids", {arvalid, rready, awvalid, wvalid, bready, ret_valid}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    ar_q.delete(); ret_q.delete(); aw_q.delete(); w_q.delete();
    @(negedge clk); #1;
    check("midrst_idle_rd", rd_rdy, 32'd1);
    check("midrst_idle_wr", wr_rdy, 32'd1);
    rt_tgt = ret_done + 1;
    issue_read(3'b100, 32'h1c000180);
    wait_read_done(rt_tgt);
    verify_read(3'b100, 32'h1c000180);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      tsel = $urandom_range(0, 3);
      rt = (tsel == 3) ? 3'b100 : 3'(tsel);
      tsel = $urandom_range(0, 3);
      wt = (tsel == 3) ? 3'b100 : 3'(tsel);
      ra = rand_addr(rt); wa = rand_addr(wt);
      ws = 4'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      ar_wait = $urandom_range(0, 3); aw_wait = $urandom_range(0, 6);
      rt_tgt = ret_done + 1; wb_tgt = b_cnt + 1;
      if (mode == 0) begin
        issue_read(rt, ra);
        wait_read_done(rt_tgt);
        verify_read(rt, ra);
      end else if (mode == 1) begin
        issue_write(wt, wa, ws, wd);
        wait_write_done(wb_tgt);
        verify_write(wt, wa, ws, wd);
      end else if (mode == 2) begin
        @(posedge clk); #1;
        wr_req = 1'b1; wr_type = wt; wr_addr = wa; wr_wstrb = ws; wr_data = wd;
        rd_req = 1'b1; rd_type = rt; rd_addr = ra;
        @(negedge clk); #1;
        check("rnd_simul_rd_rdy", rd_rdy, 32'd0);
        @(posedge clk); #1;
        wr_req = 1'b0;
        wait_rd_accept();
        wait_write_done(wb_tgt);
        wait_read_done(rt_tgt);
        check("rnd_raw_order", (ar_rise_cyc > b_cyc) ? 32'd1 : 32'd0, 32'd1);
        verify_write(wt, wa, ws, wd);
        verify_read(rt, ra);
      end else begin
        issue_read(rt, ra);
        issue_write(wt, wa, ws, wd);
        wait_read_done(rt_tgt);
        wait_write_done(wb_tgt);
        verify_read(rt, ra);
        verify_write(wt, wa, ws, wd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
